// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_if
//  Description : Control bundle between the multicycle controller and its
//                datapath. The master modport belongs to the controller: it
//                receives the instruction fields, the ALU Zero flag and the
//                memory ready strobe, and drives every mux select and write
//                enable. The slave modport is the datapath view.
//  Signals     : op[6:0], funct3[2:0], funct7b5, zero, mem_ready (to ctrl)
//                mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
//                ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0], ImmSrc[2:0],
//                ALUControl[3:0], state[3:0], retire, illegal (from ctrl)
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;

   logic       mem_req;
   logic       AdrSrc;
   logic       IRWrite;
   logic       PCWrite;
   logic       MemWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ImmSrc;
   logic [3:0] ALUControl;
   logic [3:0] state;
   logic       retire;
   logic       illegal;

   modport master (
      input  op, funct3, funct7b5, zero, mem_ready,
      output mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
             state, retire, illegal
   );

   modport slave (
      output op, funct3, funct7b5, zero, mem_ready,
      input  mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
             state, retire, illegal
   );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Main FSM plus ALU/immediate decoder for a multicycle
//                RV32I-subset datapath (lw, sw, R-type, I-type ALU, beq, jal,
//                lui) sharing one ALU and one memory. Memory accesses stall on
//                a req/ready handshake.
//  Ports       : clk   - clock, rising edge
//                reset - asynchronous, active-high
//                ctrl  - control bundle (master modport): instruction fields,
//                        Zero and mem_ready in; selects, enables, state,
//                        retire and illegal out
//  Parameters  : MEM_WAIT     - 1: honour mem_ready, 0: assume always ready
//                ILLEGAL_HALT - 1: unknown opcode halts (sticky),
//                               0: unknown opcode returns to FETCH
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
   parameter bit MEM_WAIT     = 1'b1,
   parameter bit ILLEGAL_HALT = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   multicycle_ctrl_if.master ctrl
);

   localparam logic [3:0] c_FETCH    = 4'd0;
   localparam logic [3:0] c_DECODE   = 4'd1;
   localparam logic [3:0] c_MEMADR   = 4'd2;
   localparam logic [3:0] c_MEMREAD  = 4'd3;
   localparam logic [3:0] c_MEMWB    = 4'd4;
   localparam logic [3:0] c_MEMWRITE = 4'd5;
   localparam logic [3:0] c_EXECR    = 4'd6;
   localparam logic [3:0] c_EXECI    = 4'd7;
   localparam logic [3:0] c_ALUWB    = 4'd8;
   localparam logic [3:0] c_BEQ      = 4'd9;
   localparam logic [3:0] c_JAL      = 4'd10;
   localparam logic [3:0] c_LUI      = 4'd11;
   localparam logic [3:0] c_HALT     = 4'd12;

   localparam logic [6:0] c_OP_LW    = 7'b0000011;
   localparam logic [6:0] c_OP_SW    = 7'b0100011;
   localparam logic [6:0] c_OP_R     = 7'b0110011;
   localparam logic [6:0] c_OP_I     = 7'b0010011;
   localparam logic [6:0] c_OP_BEQ   = 7'b1100011;
   localparam logic [6:0] c_OP_JAL   = 7'b1101111;
   localparam logic [6:0] c_OP_LUI   = 7'b0110111;

   localparam logic [3:0] c_ALU_ADD  = 4'b0000;
   localparam logic [3:0] c_ALU_SUB  = 4'b0001;
   localparam logic [3:0] c_ALU_AND  = 4'b0010;
   localparam logic [3:0] c_ALU_OR   = 4'b0011;
   localparam logic [3:0] c_ALU_XOR  = 4'b0100;
   localparam logic [3:0] c_ALU_SLT  = 4'b0101;
   localparam logic [3:0] c_ALU_PASS = 4'b1000;

   logic [3:0] state_q, state_d;
   logic       illegal_q, illegal_d;

   logic       w_ready;
   logic [3:0] w_funct_alu;
   logic       w_mem_req, w_adr_src, w_ir_write, w_pc_write;
   logic       w_mem_write, w_reg_write, w_retire;
   logic [1:0] w_result_src, w_alu_src_a, w_alu_src_b;
   logic [3:0] w_alu_ctrl;
   logic [2:0] w_imm_src;

   assign w_ready = MEM_WAIT ? ctrl.mem_ready : 1'b1;

   // funct3 decode shared by EXECR and EXECI; subtraction only exists in
   // R-type, which op[5] distinguishes from the I-type ALU opcode.
   always_comb begin
      w_funct_alu = c_ALU_ADD;
      case (ctrl.funct3)
         3'b000:  w_funct_alu = (ctrl.op[5] & ctrl.funct7b5) ? c_ALU_SUB : c_ALU_ADD;
         3'b010:  w_funct_alu = c_ALU_SLT;
         3'b100:  w_funct_alu = c_ALU_XOR;
         3'b110:  w_funct_alu = c_ALU_OR;
         3'b111:  w_funct_alu = c_ALU_AND;
         default: w_funct_alu = c_ALU_ADD;
      endcase
   end

   always_comb begin
      w_imm_src = 3'b000;
      case (ctrl.op)
         c_OP_SW:  w_imm_src = 3'b001;
         c_OP_BEQ: w_imm_src = 3'b010;
         c_OP_JAL: w_imm_src = 3'b011;
         c_OP_LUI: w_imm_src = 3'b100;
         default:  w_imm_src = 3'b000;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      w_mem_req    = 1'b0;
      w_adr_src    = 1'b0;
      w_ir_write   = 1'b0;
      w_pc_write   = 1'b0;
      w_mem_write  = 1'b0;
      w_reg_write  = 1'b0;
      w_retire     = 1'b0;
      w_result_src = 2'b00;
      w_alu_src_a  = 2'b00;
      w_alu_src_b  = 2'b00;
      w_alu_ctrl   = c_ALU_ADD;
      case (state_q)
         c_FETCH: begin
            // PC + 4 computed by the ALU and written straight back to PC
            w_mem_req    = 1'b1;
            w_alu_src_b  = 2'b10;
            w_result_src = 2'b10;
            w_ir_write   = w_ready;
            w_pc_write   = w_ready;
            if (w_ready) state_d = c_DECODE;
         end
         c_DECODE: begin
            // OldPC + imm parks the branch/jump target in ALUOut
            w_alu_src_a = 2'b01;
            w_alu_src_b = 2'b01;
            case (ctrl.op)
               c_OP_LW, c_OP_SW: state_d = c_MEMADR;
               c_OP_R:           state_d = c_EXECR;
               c_OP_I:           state_d = c_EXECI;
               c_OP_BEQ:         state_d = c_BEQ;
               c_OP_JAL:         state_d = c_JAL;
               c_OP_LUI:         state_d = c_LUI;
               default:          state_d = ILLEGAL_HALT ? c_HALT : c_FETCH;
            endcase
         end
         c_MEMADR: begin
            w_alu_src_a = 2'b10;
            w_alu_src_b = 2'b01;
            state_d     = (ctrl.op == c_OP_SW) ? c_MEMWRITE : c_MEMREAD;
         end
         c_MEMREAD: begin
            w_mem_req = 1'b1;
            w_adr_src = 1'b1;
            if (w_ready) state_d = c_MEMWB;
         end
         c_MEMWB: begin
            w_result_src = 2'b01;
            w_reg_write  = 1'b1;
            w_retire     = 1'b1;
            state_d      = c_FETCH;
         end
         c_MEMWRITE: begin
            // strobe held stable until the memory accepts it
            w_mem_req   = 1'b1;
            w_adr_src   = 1'b1;
            w_mem_write = 1'b1;
            w_retire    = w_ready;
            if (w_ready) state_d = c_FETCH;
         end
         c_EXECR: begin
            w_alu_src_a = 2'b10;
            w_alu_src_b = 2'b00;
            w_alu_ctrl  = w_funct_alu;
            state_d     = c_ALUWB;
         end
         c_EXECI: begin
            w_alu_src_a = 2'b10;
            w_alu_src_b = 2'b01;
            w_alu_ctrl  = w_funct_alu;
            state_d     = c_ALUWB;
         end
         c_LUI: begin
            w_alu_src_b = 2'b01;
            w_alu_ctrl  = c_ALU_PASS;
            state_d     = c_ALUWB;
         end
         c_ALUWB: begin
            w_result_src = 2'b00;
            w_reg_write  = 1'b1;
            w_retire     = 1'b1;
            state_d      = c_FETCH;
         end
         c_BEQ: begin
            // Result selects ALUOut, which still holds the target from DECODE
            w_alu_src_a  = 2'b10;
            w_alu_src_b  = 2'b00;
            w_alu_ctrl   = c_ALU_SUB;
            w_pc_write   = ctrl.zero;
            w_retire     = 1'b1;
            state_d      = c_FETCH;
         end
         c_JAL: begin
            // PC <- target (ALUOut) while the ALU forms OldPC + 4 for rd
            w_alu_src_a  = 2'b01;
            w_alu_src_b  = 2'b10;
            w_pc_write   = 1'b1;
            state_d      = c_ALUWB;
         end
         c_HALT: begin
            state_d = c_HALT;
         end
         default: begin
            state_d = c_FETCH;
         end
      endcase
   end

   assign illegal_d = illegal_q | (state_d == c_HALT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= c_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // Enables are qualified by reset directly so they drop in the same cycle
   // reset rises, without waiting for the state register to settle.
   assign ctrl.mem_req    = w_mem_req   & ~reset;
   assign ctrl.IRWrite    = w_ir_write  & ~reset;
   assign ctrl.PCWrite    = w_pc_write  & ~reset;
   assign ctrl.MemWrite   = w_mem_write & ~reset;
   assign ctrl.RegWrite   = w_reg_write & ~reset;
   assign ctrl.retire     = w_retire    & ~reset;
   assign ctrl.AdrSrc     = w_adr_src;
   assign ctrl.ResultSrc  = w_result_src;
   assign ctrl.ALUSrcA    = w_alu_src_a;
   assign ctrl.ALUSrcB    = w_alu_src_b;
   assign ctrl.ALUControl = w_alu_ctrl;
   assign ctrl.ImmSrc     = w_imm_src;
   assign ctrl.state      = state_q;
   assign ctrl.illegal    = illegal_q;

endmodule
`default_nettype wire
